// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and the
// rule for sizing the iteration counter.
package divider_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The counter must be able to hold nBit itself, hence nBit+1 values.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/divider_if.sv
// Request/result bundle of the divider. The master raises start with the
// operands; the slave reports busy, a one-cycle done pulse and held results.
interface divider_if #(
    parameter int nBit = 16
);
    logic            start;
    logic [nBit-1:0] dividend;
    logic [nBit-1:0] divisor;
    logic            busy;
    logic            done;
    logic [nBit-1:0] quotient;
    logic [nBit-1:0] remainder;
    logic            div_by_zero;

    // start is only sampled by the slave while it is idle; there is no
    // ready signal, so a master must watch busy or done to pace requests.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift {A,Q} left, try A-M and
// keep the difference when it does not go negative.
module div_step #(
    parameter int nBit = 16
) (
    input  logic [nBit:0]   a_i,
    input  logic [nBit-1:0] q_i,
    input  logic [nBit-1:0] m_i,
    output logic [nBit:0]   a_o,
    output logic [nBit-1:0] q_o
);
    logic [nBit:0] a_sh;
    logic [nBit:0] trial;
    logic          neg;

    always_comb begin
        a_sh  = {a_i[nBit-1:0], q_i[nBit-1]};
        trial = a_sh - {1'b0, m_i};
        // a_sh < 2*M, so the top bit of the difference is a valid sign bit.
        neg   = trial[nBit];
        a_o   = neg ? a_sh : trial;
        q_o   = {q_i[nBit-2:0], ~neg};
    end
endmodule

// File: rtl/divider_core.sv
// Multi-cycle unsigned restoring divider: one quotient bit per CALC cycle,
// results registered on entry to DONE and held until the next completion.
module divider_core
    import divider_pkg::*;
#(
    parameter int nBit = 16
) (
    input  logic       clk,
    input  logic       clr,
    divider_if.slave   bus,
    output logic [1:0] dbg_state
);
    localparam int CW = cnt_width(nBit);

    logic [1:0]      state_q, state_d;
    logic [nBit:0]   a_q, a_d;
    logic [nBit-1:0] q_q, q_d;
    logic [nBit-1:0] m_q, m_d;
    logic [CW-1:0]   count_q, count_d;
    logic [nBit-1:0] quot_q, quot_d;
    logic [nBit-1:0] rem_q, rem_d;
    logic            dbz_q, dbz_d;

    logic [nBit:0]   step_a;
    logic [nBit-1:0] step_q;

    div_step #(.nBit(nBit)) u_step (
        .a_i (a_q),
        .q_i (q_q),
        .m_i (m_q),
        .a_o (step_a),
        .q_o (step_q)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        count_d = count_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        // Division by zero skips CALC entirely.
                        state_d = ST_DONE;
                        quot_d  = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                        a_d     = '0;
                        q_d     = bus.dividend;
                        m_d     = bus.divisor;
                        count_d = CW'(nBit);
                    end
                end
            end
            ST_CALC: begin
                a_d     = step_a;
                q_d     = step_q;
                count_d = count_q - CW'(1);
                // Final iteration publishes the results as DONE is entered.
                if (count_q == CW'(1)) begin
                    state_d = ST_DONE;
                    quot_d  = step_q;
                    rem_d   = step_a[nBit-1:0];
                    dbz_d   = 1'b0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            count_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            count_q <= count_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_divider_core.sv
// Directed bench for divider_core at nBit=16: hand-computed quotients,
// latency, busy length, start masking and asynchronous clear.
module tb_divider_core;
    import divider_pkg::*;

    logic       clk;
    logic       clr;
    logic [1:0] dbg_state;
    int         checks;
    int         errors;
    int         cyc;
    logic [32:0] exp_q[$];

    divider_if #(.nBit(16)) bus ();

    divider_core #(.nBit(16)) dut (
        .clk       (clk),
        .clr       (clr),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: present operands at a negedge, hold start over one rising edge
    task automatic start_op(input logic [15:0] dd, input logic [15:0] dv);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = dd;
        bus.divisor  = dv;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Called at the first negedge after the accepting edge (j=0).
    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy,
                             output int done_cyc);
        int lat;
        int busy_n;
        int done_n;
        logic [32:0] e;
        lat = -1;
        busy_n = 0;
        done_n = 0;
        done_cyc = -1;
        for (int j = 0; j < 40; j++) begin
            if (bus.done) begin
                done_n++;
                if (lat < 0) begin
                    lat = j;
                    done_cyc = cyc;
                end
            end
            if (!bus.busy) break;
            busy_n++;
            @(negedge clk);
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, busy_n, exp_busy);
        check({tag, "_done_pulses"}, done_n, 1);
        e = exp_q.pop_front();
        check({tag, "_quotient"}, bus.quotient, e[32:17]);
        check({tag, "_remainder"}, bus.remainder, e[16:1]);
        check({tag, "_div_by_zero"}, bus.div_by_zero, e[0]);
    endtask

    task automatic run_div(input string tag, input logic [15:0] dd, input logic [15:0] dv,
                           input logic [15:0] eq, input logic [15:0] er, input logic ez);
        int dc;
        exp_q.push_back({eq, er, ez});
        start_op(dd, dv);
        if (ez) wait_done(tag, 0, 1, dc);
        else    wait_done(tag, 16, 17, dc);
    endtask

    initial begin
        int c1;
        int c2;
        int seen;
        checks = 0;
        errors = 0;
        cyc = 0;
        clr = 1'b1;
        bus.start = 1'b1;
        bus.dividend = 16'd100;
        bus.divisor = 16'd7;
        #3;
        check("reset_state", dbg_state, ST_IDLE);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_quotient", bus.quotient, 16'h0);
        check("reset_remainder", bus.remainder, 16'h0);
        check("reset_dbz", bus.div_by_zero, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("start_ignored_in_clr", bus.busy, 1'b0);
        bus.start = 1'b0;
        clr = 1'b0;

        run_div("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
        run_div("ffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
        run_div("ffff_ffff", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
        run_div("d3_10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0);
        run_div("d5_0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1);
        run_div("d9_3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0);

        // start held high with new operands throughout CALC of 100/7
        exp_q.push_back({16'd14, 16'd2, 1'b0});
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 16'd100;
        bus.divisor = 16'd7;
        @(posedge clk);
        @(negedge clk);
        bus.dividend = 16'd50;
        bus.divisor = 16'd5;
        wait_done("held_first", 16, 17, c1);
        exp_q.push_back({16'd10, 16'd0, 1'b0});
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("held_second", 16, 17, c2);
        check("back_to_back_period", c2 - c1, 18);

        // asynchronous clear in the middle of a calculation
        start_op(16'd100, 16'd7);
        repeat (7) @(negedge clk);
        check("calc_state_before_clr", dbg_state, ST_CALC);
        #2 clr = 1'b1;
        #1;
        check("clr_quotient", bus.quotient, 16'h0);
        check("clr_remainder", bus.remainder, 16'h0);
        check("clr_dbz", bus.div_by_zero, 1'b0);
        check("clr_busy", bus.busy, 1'b0);
        check("clr_done", bus.done, 1'b0);
        check("clr_state", dbg_state, ST_IDLE);
        #1 clr = 1'b0;
        seen = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        check("no_activity_after_clr", seen, 0);
        run_div("d20_6", 16'd20, 16'd6, 16'd3, 16'd2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
